// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I sequencer and its datapath.
// The controller takes the master side; the datapath takes the slave side.
interface multicycle_controller_if;
   logic [6:0] op;
   logic       zero;
   logic       mem_ready;
   logic       PCWrite;
   logic       AdrSrc;
   logic       IRWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] ImmSrc;
   logic       illegal;

   modport master (
      input  op, zero, mem_ready,
      output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
   );

   modport slave (
      output op, zero, mem_ready,
      input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
   );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_controller_if.master ctl,
   output logic [3:0]             state,
   output logic [CNT_W-1:0]       instret
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t state_q;
   state_t state_d;
   logic   retire;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (rst) begin
         state_q <= S_FETCH;
         instret <= '0;
      end else begin
         state_q <= state_d;
         if (retire) instret <= instret + CNT_W'(1);
      end
   end

   assign state = state_q;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d       = S_FETCH;
      retire        = 1'b0;
      ctl.PCWrite   = 1'b0;
      ctl.AdrSrc    = 1'b0;
      ctl.IRWrite   = 1'b0;
      ctl.MemWrite  = 1'b0;
      ctl.RegWrite  = 1'b0;
      ctl.illegal   = 1'b0;
      ctl.ResultSrc = 2'b00;
      ctl.ALUSrcA   = 2'b00;
      ctl.ALUSrcB   = 2'b00;
      ctl.ALUOp     = 2'b00;

      case (state_q)
         S_FETCH: begin
            ctl.ALUSrcB   = 2'b10;
            ctl.ResultSrc = 2'b10;
            ctl.IRWrite   = ctl.mem_ready;
            ctl.PCWrite   = ctl.mem_ready;
            state_d       = ctl.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Precompute branch/jump target from OldPC + imm into ALUOut.
            ctl.ALUSrcA = 2'b01;
            ctl.ALUSrcB = 2'b01;
            case (ctl.op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            ctl.ALUSrcA = 2'b10;
            ctl.ALUSrcB = 2'b01;
            state_d     = (ctl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            ctl.AdrSrc = 1'b1;
            state_d    = ctl.mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ctl.ResultSrc = 2'b01;
            ctl.RegWrite  = 1'b1;
            retire        = 1'b1;
         end
         S_MEMWRITE: begin
            ctl.AdrSrc   = 1'b1;
            ctl.MemWrite = 1'b1;
            retire       = ctl.mem_ready;
            state_d      = ctl.mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            ctl.ALUSrcA = 2'b10;
            ctl.ALUOp   = 2'b10;
            state_d     = S_ALUWB;
         end
         S_EXECI: begin
            ctl.ALUSrcA = 2'b10;
            ctl.ALUSrcB = 2'b01;
            ctl.ALUOp   = 2'b10;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            ctl.RegWrite = 1'b1;
            retire       = 1'b1;
         end
         S_BEQ: begin
            ctl.ALUSrcA = 2'b10;
            ctl.ALUOp   = 2'b01;
            ctl.PCWrite = ctl.zero;
            retire      = 1'b1;
         end
         S_JAL: begin
            ctl.ALUSrcA = 2'b01;
            ctl.ALUSrcB = 2'b10;
            ctl.PCWrite = 1'b1;
            state_d     = S_ALUWB;
         end
         S_ILLEGAL: ctl.illegal = 1'b1;
         default:   state_d = S_FETCH;
      endcase

      // Reset abandons the current instruction: no strobes, FETCH selects.
      if (rst) begin
         retire        = 1'b0;
         ctl.PCWrite   = 1'b0;
         ctl.IRWrite   = 1'b0;
         ctl.MemWrite  = 1'b0;
         ctl.RegWrite  = 1'b0;
         ctl.illegal   = 1'b0;
         ctl.AdrSrc    = 1'b0;
         ctl.ALUSrcA   = 2'b00;
         ctl.ALUSrcB   = 2'b10;
         ctl.ALUOp     = 2'b00;
         ctl.ResultSrc = 2'b10;
      end
   end

   always_comb begin
      case (ctl.op)
         OP_STORE:  ctl.ImmSrc = 2'b01;
         OP_BRANCH: ctl.ImmSrc = 2'b10;
         OP_JAL:    ctl.ImmSrc = 2'b11;
         default:   ctl.ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-level path model with per-cycle output compare,
// directed scenarios plus randomized instruction streams with random wait states.
module tb_multicycle_controller;

   localparam int CNT_W = 4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   typedef struct packed {
      logic       pcw, adr, irw, memw, regw, ill;
      logic [1:0] res, srca, srcb, aluop;
   } outs_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       state;
   logic [CNT_W-1:0] instret;

   multicycle_controller_if bus ();

   multicycle_controller #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .ctl     (bus.master),
      .state   (state),
      .instret (instret)
   );

   always #5 clk = ~clk;

   int    total = 0;
   int    bad = 0;
   int    model_cnt = 0;
   int    ill_cnt = 0;
   int    irw_cnt = 0;
   bit    chk_en = 1'b0;
   bit    exp_chk_st;
   int    exp_st;
   outs_t exp_o;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Outputs as listed for each state; reset forces FETCH selects, no strobes.
   function automatic outs_t spec_out(input int st, input logic mr, input logic z, input logic r);
      outs_t e = '0;
      if (r) begin
         e.srcb = 2'b10; e.res = 2'b10;
         return e;
      end
      case (st)
         0:  begin e.srcb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
         1:  begin e.srca = 2'b01; e.srcb = 2'b01; end
         2:  begin e.srca = 2'b10; e.srcb = 2'b01; end
         3:  e.adr = 1'b1;
         4:  begin e.res = 2'b01; e.regw = 1'b1; end
         5:  begin e.adr = 1'b1; e.memw = 1'b1; end
         6:  begin e.srca = 2'b10; e.aluop = 2'b10; end
         7:  begin e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 2'b10; end
         8:  e.regw = 1'b1;
         9:  begin e.srca = 2'b10; e.aluop = 2'b01; e.pcw = z; end
         10: begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; end
         11: e.ill = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   function automatic logic [1:0] imm_model(input logic [6:0] op);
      if (op == OP_STORE)  return 2'b01;
      if (op == OP_BRANCH) return 2'b10;
      if (op == OP_JAL)    return 2'b11;
      return 2'b00;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         outs_t act;
         act = '{pcw: bus.PCWrite, adr: bus.AdrSrc, irw: bus.IRWrite, memw: bus.MemWrite,
                 regw: bus.RegWrite, ill: bus.illegal, res: bus.ResultSrc,
                 srca: bus.ALUSrcA, srcb: bus.ALUSrcB, aluop: bus.ALUOp};
         if (exp_chk_st) check("state", 32'(state), 32'(exp_st));
         check($sformatf("outputs_st%0d", exp_st), 32'(act), 32'(exp_o));
         check("instret", 32'(instret), 32'(model_cnt % (1 << CNT_W)));
         check("immsrc", 32'(bus.ImmSrc), 32'(imm_model(bus.op)));
         if (bus.illegal) ill_cnt++;
         if (bus.IRWrite) irw_cnt++;
      end
   end

   task automatic step(input int st, input logic mr, input logic z, input logic r, input bit chk_st);
      rst = r; bus.mem_ready = mr; bus.zero = z;
      exp_o = spec_out(st, mr, z, r);
      exp_st = st; exp_chk_st = chk_st; chk_en = 1'b1;
      @(posedge clk); #1;
      if (r) model_cnt = 0;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(0, 1'b1, 1'(($urandom)), 1'b1, 1'b0);
   endtask

   // Build the state path of one instruction from its opcode and wait counts, then play it.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z,
                            output int cycles);
      int   sq[$];
      logic mq[$];
      sq = {}; mq = {};
      bus.op = op;
      for (int i = 0; i < fw; i++) begin sq.push_back(0); mq.push_back(1'b0); end
      sq.push_back(0); mq.push_back(1'b1);
      sq.push_back(1); mq.push_back(1'(($urandom)));
      case (op)
         OP_LOAD: begin
            sq.push_back(2); mq.push_back(1'(($urandom)));
            for (int i = 0; i < mw; i++) begin sq.push_back(3); mq.push_back(1'b0); end
            sq.push_back(3); mq.push_back(1'b1);
            sq.push_back(4); mq.push_back(1'(($urandom)));
         end
         OP_STORE: begin
            sq.push_back(2); mq.push_back(1'(($urandom)));
            for (int i = 0; i < mw; i++) begin sq.push_back(5); mq.push_back(1'b0); end
            sq.push_back(5); mq.push_back(1'b1);
         end
         OP_RTYPE:  begin sq.push_back(6); mq.push_back(1'(($urandom))); sq.push_back(8); mq.push_back(1'(($urandom))); end
         OP_ITYPE:  begin sq.push_back(7); mq.push_back(1'(($urandom))); sq.push_back(8); mq.push_back(1'(($urandom))); end
         OP_BRANCH: begin sq.push_back(9); mq.push_back(1'(($urandom))); end
         OP_JAL:    begin sq.push_back(10); mq.push_back(1'(($urandom))); sq.push_back(8); mq.push_back(1'(($urandom))); end
         default:   begin sq.push_back(11); mq.push_back(1'(($urandom))); end
      endcase
      for (int i = 0; i < sq.size(); i++)
         step(sq[i], mq[i], (sq[i] == 9) ? z : 1'(($urandom)), 1'b0, 1'b1);
      if (sq[sq.size()-1] != 11) model_cnt++;
      cycles = sq.size();
   endtask

   initial begin
      int cyc;
      int ill0;
      int irw0;
      logic [6:0] rop;
      rst = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.op = OP_RTYPE;
      @(posedge clk); #1;

      do_reset(2);
      check("reset_state", 32'(state), 32'd0);
      check("reset_instret", 32'(instret), 32'd0);

      run_instr(OP_LOAD, 0, 0, 1'b0, cyc);
      check("lat_lw", cyc, 5);
      check("instret_after_lw", 32'(instret), 32'd1);
      run_instr(OP_STORE, 0, 0, 1'b0, cyc);
      check("lat_sw", cyc, 4);
      check("instret_after_sw", 32'(instret), 32'd2);

      irw0 = irw_cnt;
      run_instr(OP_LOAD, 3, 2, 1'b0, cyc);
      check("lat_lw_wait", cyc, 10);
      check("irwrite_pulses", irw_cnt - irw0, 1);

      run_instr(OP_BRANCH, 0, 0, 1'b1, cyc);
      check("lat_beq", cyc, 3);
      run_instr(OP_BRANCH, 0, 0, 1'b0, cyc);
      check("instret_after_beq", 32'(instret), 32'd5);
      run_instr(OP_JAL, 0, 0, 1'b0, cyc);
      check("lat_jal", cyc, 4);
      check("instret_after_jal", 32'(instret), 32'd6);

      ill0 = ill_cnt;
      run_instr(OP_BAD, 0, 0, 1'b0, cyc);
      check("lat_illegal", cyc, 3);
      check("illegal_pulses", ill_cnt - ill0, 1);
      check("instret_after_illegal", 32'(instret), 32'd6);
      run_instr(OP_RTYPE, 0, 0, 1'b0, cyc);
      run_instr(OP_ITYPE, 1, 0, 1'b0, cyc);
      check("lat_itype_1wait", cyc, 5);

      // Reset while a store is waiting on memory.
      bus.op = OP_STORE;
      step(0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(2, 1'b0, 1'b0, 1'b0, 1'b1);
      step(5, 1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1; bus.mem_ready = 1'b0;
      exp_o = spec_out(5, 1'b0, 1'b0, 1'b1); exp_st = 5; exp_chk_st = 1'b1;
      @(negedge clk); #1;
      check("memwrite_in_reset", 32'(bus.MemWrite), 32'd0);
      @(posedge clk); #1;
      model_cnt = 0;
      check("state_after_reset", 32'(state), 32'd0);
      check("instret_after_reset", 32'(instret), 32'd0);

      for (int i = 0; i < 16; i++) run_instr(OP_RTYPE, 0, 0, 1'b0, cyc);
      check("instret_wrap", 32'(instret), 32'd0);

      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 6))
            0: rop = OP_LOAD;
            1: rop = OP_STORE;
            2: rop = OP_RTYPE;
            3: rop = OP_ITYPE;
            4: rop = OP_BRANCH;
            5: rop = OP_JAL;
            default: rop = 7'($urandom);
         endcase
         run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), 1'(($urandom)), cyc);
         if ($urandom_range(0, 19) == 0) do_reset(1 + $urandom_range(0, 1));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control FSM for the multi-cycle RV32I core variant, which has one shared memory port and one shared ALU. Each instruction is walked through fetch, decode, execute, memory and writeback steps. The block drives every datapath select and strobe per state, and holds on memory wait states through a `mem_ready` handshake. It reuses the single-cycle decode encodings for `ImmSrc` and `ALUOp`, so the existing ALU decoder and immediate extender attach unchanged.

## Interface
Parameters:
- `CNT_W`, default 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  7  opcode field of the instruction register (valid from DECODE onward).
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  instruction register and OldPC enable.
- `MemWrite`  out  1  memory write strobe.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ALUOp`  out  2  to the ALU decoder: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `ImmSrc`  out  2  immediate format, combinational from `op`: load/I = 00, S = 01, B = 10, JAL = 11, other = 00.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.
- `state`  out  4  current state code, for debug.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=11. Codes 12–15 go to FETCH on the next cycle, with all strobes 0.

Outputs per state. Unlisted selects are 00/0 and unlisted strobes are 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=`mem_ready`. Stay while `!mem_ready`; otherwise go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - else → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1. Stay while `!mem_ready`, else go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1; MemWrite stays high through wait cycles. Go to FETCH on `mem_ready`.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state is FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=`zero`. Next state is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next state is ALUWB, which writes PC+4 to rd.
- ILLEGAL: illegal=1, no other strobes. Next state is FETCH.

`instret` increments by 1 on the cycle the FSM leaves any of these: MEMWB, MEMWRITE (with `mem_ready`), ALUWB, BEQ. It wraps modulo 2^CNT_W and does not count ILLEGAL.

## Timing
- Reset: while `rst`=1 at a rising edge, the next state is FETCH and `instret` becomes 0. While `rst` is high, all strobes (PCWrite, IRWrite, MemWrite, RegWrite, illegal) are forced to 0, independent of `mem_ready`. Selects take their FETCH values.
- Reset asserted mid-instruction (including during a memory wait) abandons the instruction with no write strobe that cycle. It is not counted.
- Selects and ALUOp are Moore, decoded from the state register. PCWrite and IRWrite in FETCH, and PCWrite in BEQ, are Mealy on `mem_ready`/`zero`.
- Minimum latency at zero wait states:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
- Each memory wait cycle adds exactly 1 cycle. `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.
- `op` is sampled only in DECODE and MEMADR. It must stay stable from IRWrite until the next FETCH completes.

## Test plan
- Reset: hold `rst` 2 cycles with `mem_ready`=1, then release → state=0, all strobes 0 during reset, `instret`=0. The first FETCH cycle after release shows IRWrite=PCWrite=1.
- Load/store: lw (op=0000011) with `mem_ready`=1 → states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; `instret`=1. Then sw → states 0,1,2,5,0 with MemWrite=1 only in state 5; `instret`=2.
- Wait states: lw with `mem_ready` low for 3 cycles in FETCH and 2 in MEMREAD → IRWrite pulses once, MEMREAD lasts 3 cycles, total 10 cycles.
- Branch and jump:
  - beq with zero=1 → PCWrite=1 in state 9.
  - beq with zero=0 → PCWrite=0 in state 9; `instret` still increments.
  - jal → states 0,1,10,8,0, with PCWrite=1 in state 10.
- Illegal opcode: op=1111111 → states 0,1,11,0; illegal=1 for exactly one cycle; no RegWrite or MemWrite; `instret` unchanged.
- Reset mid-operation and wrap:
  - Assert `rst` in MEMWRITE with `mem_ready`=0 → MemWrite drops to 0 that cycle; state=0 next.
  - With CNT_W=4, retire 16 R-type instructions → `instret` wraps to 0.
